instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Front stage of the 16-bit pipelined core: holds the program counter, issues word reads to instruction memory over a req/ack handshake, and buffers returned instructions in a small FIFO. It feeds the decode stage with `instruction_if`, `next_program_counter_if` and a valid flag. It accepts back-pressure from decode, a predicted-taken redirect from decode/branch predictor, and a mispredict redirect from execute.

## Interface
Parameters:
- `ADDR_W`, 16, PC / memory address width (word addressed)
- `INSTR_W`, 16, instruction width
- `RESET_PC`, 16'h0000, first fetch address after reset
- `BUF_DEPTH`, 2, fetch buffer entries (≥2)

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `imem_req_if`  out  1  read request to instruction memory
- `imem_addr_if`  out  ADDR_W  read address
- `imem_ack`  in  1  request accepted; `imem_data` valid this cycle
- `imem_data`  in  INSTR_W  read data
- `stall_id`  in  1  decode cannot accept an instruction this cycle
- `branch_prediction_bp`  in  1  decode instruction predicted taken; refetch from `target_address_id`
- `target_address_id`  in  ADDR_W  predicted target
- `redirect_ex`  in  1  execute mispredict; refetch from `redirect_addr_ex`
- `redirect_addr_ex`  in  ADDR_W  corrected PC
- `instruction_if`  out  INSTR_W  instruction to decode
- `next_program_counter_if`  out  ADDR_W  fetch address of that instruction + 1
- `valid_if`  out  1  `instruction_if` / `next_program_counter_if` valid

## Operation
- FSM states: FETCH, DRAIN.
- FETCH: `imem_req_if` = (buffer count < BUF_DEPTH) or a request is already pending; `imem_addr_if` = PC. On ack: push {data, PC+1} into buffer, PC ← PC+1.
- Once asserted, `imem_req_if` and `imem_addr_if` stay stable until `imem_ack`; requests are never withdrawn.
- Pop when `valid_if && !stall_id`. Push and pop in the same cycle are allowed; count is unchanged.
- Redirect: `redirect_ex` takes priority over `branch_prediction_bp`. A redirect flushes the buffer (count ← 0) and sets PC ← selected address.
  - If no request is pending, or the ack arrives in the redirect cycle (ack data discarded): stay in FETCH.
  - If a request is pending without ack: go to DRAIN.
- DRAIN: keep the old request asserted. On ack, discard the data and go to FETCH. A further redirect in DRAIN overwrites the saved PC (latest wins).
- `valid_if` = buffer non-empty. When `valid_if`=0, `instruction_if` = 16'h0000 and `next_program_counter_if` = 16'h0000.
- PC arithmetic is modulo 2^ADDR_W: 16'hFFFF + 1 = 16'h0000.
- `imem_ack` while `imem_req_if`=0 is ignored.

## Timing
- Reset (async assert): PC = RESET_PC, state FETCH, count 0, `imem_req_if`=0, `imem_addr_if`=RESET_PC, `valid_if`=0, `instruction_if`=0, `next_program_counter_if`=0.
- First cycle after reset release: `imem_req_if`=1, `imem_addr_if`=RESET_PC.
- Latency: ack in cycle N → `valid_if`=1 in cycle N+1.
- Throughput: zero-wait memory and no stall give one instruction per cycle.
- Full buffer: `imem_req_if` drops in the cycle after the push that fills it, unless that push coincides with a pop. There is no overflow.
- Redirect in cycle N: `valid_if`=0 in N+1. The new address is requested in N+1 (FETCH) or in the cycle after the drain ack (DRAIN).
- `rst` asserted mid-transaction: all state returns to reset values immediately. A late ack is ignored.

## Structure
- Shared package `pipeline_pkg`: `ADDR_W`, `INSTR_W`, NOP encoding 16'h0000, fetch FSM state enum.
- Sub-module `fetch_buffer`: parameterised FIFO of {instruction, next PC}.
  - Ports: push, pop, flush, count, head.
  - Flush overrides push in the same cycle.
- Top level holds the PC, the FSM and the redirect mux.

## Test plan
- Reset release, zero-wait memory returning data = addr ^ 16'hA5A5: `imem_addr_if` 0,1,2,… from cycle 1; `valid_if` from cycle 2; `next_program_counter_if` 1,2,3 paired with 16'hA5A5, 16'hA5A4, 16'hA5A7.
- `stall_id`=1 for 5 cycles: buffer fills to 2, `imem_req_if` drops, outputs hold. Release: instructions resume in order, none lost or duplicated.
- `branch_prediction_bp`=1 with `target_address_id`=16'h0040, no pending request: next request addr 16'h0040; buffered instructions dropped; first valid has `next_program_counter_if`=16'h0041.
- Memory with 3-cycle ack; `redirect_ex`=1, `redirect_addr_ex`=16'h0100 one cycle after request of 16'h0005:
  - DRAIN holds address 16'h0005 until ack; its data is never output.
  - The next request is 16'h0100.
- `redirect_ex` (16'h0200) and `branch_prediction_bp` (16'h0300) in the same cycle: fetch resumes at 16'h0200.
- PC wrap: RESET_PC=16'hFFFF gives fetches at 16'hFFFF then 16'h0000, with `next_program_counter_if` 16'h0000 then 16'h0001.
- `rst` pulse mid-request: outputs return to reset values immediately; the stray ack is ignored.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared definitions for the 16-bit pipelined core: widths, NOP encoding and
// the fetch-stage FSM state type.
package pipeline_pkg;
  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 16;
  localparam logic [15:0] NOP = 16'h0000;

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;
endpackage

// File: rtl/fetch_buffer.sv
// Small circular FIFO holding fetched {instruction, next PC} entries.
// A flush empties it and overrides any push in the same cycle.
module fetch_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic              i_flush,
  input  logic [DATA_W-1:0] i_data,
  output logic [CNT_W-1:0]  o_count,
  output logic [DATA_W-1:0] o_head
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_push;
  logic              w_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_pop  = i_pop && (r_count != '0);
  assign w_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];
endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, req/ack instruction-memory interface, redirect handling and
// the fetch buffer that feeds decode.
module instruction_fetch #(
  parameter int                ADDR_W    = pipeline_pkg::ADDR_W,
  parameter int                INSTR_W   = pipeline_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int                BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req_if,
  output logic [ADDR_W-1:0]  imem_addr_if,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               stall_id,
  input  logic               branch_prediction_bp,
  input  logic [ADDR_W-1:0]  target_address_id,
  input  logic               redirect_ex,
  input  logic [ADDR_W-1:0]  redirect_addr_ex,
  output logic [INSTR_W-1:0] instruction_if,
  output logic [ADDR_W-1:0]  next_program_counter_if,
  output logic               valid_if
);
  import pipeline_pkg::*;

  localparam int ENTRY_W = INSTR_W + ADDR_W;
  localparam int CNT_W   = $clog2(BUF_DEPTH + 1);

  fetch_state_e       r_state;
  fetch_state_e       w_state_nxt;
  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  r_drain_addr;
  logic [ADDR_W-1:0]  w_pc_inc;
  logic [ADDR_W-1:0]  w_redir_addr;
  logic               w_redir;
  logic               w_req;
  logic [ADDR_W-1:0]  w_addr;
  logic               w_ack;
  logic               w_push;
  logic               w_pop;
  logic [CNT_W-1:0]   w_count;
  logic [ENTRY_W-1:0] w_head;

  assign w_redir      = redirect_ex | branch_prediction_bp;
  assign w_redir_addr = redirect_ex ? redirect_addr_ex : target_address_id;
  assign w_pc_inc     = r_pc + 1'b1;

  // Requests are gated off while reset is held; stray acks then do nothing.
  assign imem_req_if  = w_req & ~rst;
  assign imem_addr_if = w_addr;
  assign w_ack        = imem_ack & imem_req_if;
  assign w_push       = (r_state == FETCH) && w_ack;
  assign w_pop        = valid_if && !stall_id;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= FETCH;
    else     r_state <= w_state_nxt;
  end

  // A request raised this cycle cannot be withdrawn, so a redirect without a
  // same-cycle ack must wait for it in DRAIN.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FETCH:   if (w_redir && imem_req_if && !w_ack) w_state_nxt = DRAIN;
      DRAIN:   if (w_ack) w_state_nxt = FETCH;
      default: w_state_nxt = FETCH;
    endcase
  end

  // In FETCH no push happens while a request is outstanding, so the count
  // cannot reach BUF_DEPTH mid-request and the request stays asserted.
  always_comb begin
    w_req  = 1'b0;
    w_addr = r_pc;
    case (r_state)
      FETCH: begin
        w_req  = (w_count < CNT_W'(BUF_DEPTH));
        w_addr = r_pc;
      end
      DRAIN: begin
        w_req  = 1'b1;
        w_addr = r_drain_addr;
      end
      default: begin
        w_req  = 1'b0;
        w_addr = r_pc;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_drain_addr <= RESET_PC;
    end else begin
      if (w_redir)     r_pc <= w_redir_addr;
      else if (w_push) r_pc <= w_pc_inc;
      if (r_state == FETCH && w_state_nxt == DRAIN) r_drain_addr <= r_pc;
    end
  end

  fetch_buffer #(
    .DATA_W (ENTRY_W),
    .DEPTH  (BUF_DEPTH),
    .CNT_W  (CNT_W)
  ) u_fetch_buffer (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_redir),
    .i_data  ({imem_data, w_pc_inc}),
    .o_count (w_count),
    .o_head  (w_head)
  );

  assign valid_if                = (w_count != '0);
  assign instruction_if          = valid_if ? w_head[ENTRY_W-1:ADDR_W] : INSTR_W'(NOP);
  assign next_program_counter_if = valid_if ? w_head[ADDR_W-1:0] : '0;
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: cycle-by-cycle vector table plus
// hand-written sequences for PC wrap and a reset pulse mid-request.
module tb_instruction_fetch;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req, ack, stall, bp, rex, valid;
  logic [15:0] addr, data, tgt, raddr, instr, npc;
  logic        req2, ack2, valid2;
  logic [15:0] addr2, data2, instr2, npc2;

  int   ack_wait;
  int   wcnt;
  logic force_ack;
  int   checks = 0;
  int   errors = 0;

  // Memory model: acks once a request has waited ack_wait cycles.
  assign ack  = force_ack | (req && (wcnt >= ack_wait));
  assign data = addr ^ 16'hA5A5;
  always @(posedge clk or posedge rst) begin
    if (rst)              wcnt <= 0;
    else if (req && !ack) wcnt <= wcnt + 1;
    else                  wcnt <= 0;
  end

  assign ack2  = req2;
  assign data2 = addr2 ^ 16'hA5A5;

  instruction_fetch dut (
    .clk(clk), .rst(rst),
    .imem_req_if(req), .imem_addr_if(addr), .imem_ack(ack), .imem_data(data),
    .stall_id(stall), .branch_prediction_bp(bp), .target_address_id(tgt),
    .redirect_ex(rex), .redirect_addr_ex(raddr),
    .instruction_if(instr), .next_program_counter_if(npc), .valid_if(valid)
  );

  instruction_fetch #(.RESET_PC(16'hFFFF)) dut_wrap (
    .clk(clk), .rst(rst),
    .imem_req_if(req2), .imem_addr_if(addr2), .imem_ack(ack2), .imem_data(data2),
    .stall_id(1'b0), .branch_prediction_bp(1'b0), .target_address_id(16'h0000),
    .redirect_ex(1'b0), .redirect_addr_ex(16'h0000),
    .instruction_if(instr2), .next_program_counter_if(npc2), .valid_if(valid2)
  );

  typedef struct packed {
    logic        stall;
    logic        bp;
    logic [15:0] tgt;
    logic        rex;
    logic [15:0] raddr;
    logic        req;
    logic [15:0] addr;
    logic        valid;
    logic [15:0] instr;
    logic [15:0] npc;
  } vec_t;

  vec_t vecs [0:27];

  function automatic vec_t mk(input logic s, input logic b, input logic [15:0] t,
                              input logic r, input logic [15:0] ra,
                              input logic e_req, input logic [15:0] e_addr,
                              input logic e_valid, input logic [15:0] e_instr,
                              input logic [15:0] e_npc);
    vec_t v;
    v.stall = s; v.bp = b; v.tgt = t; v.rex = r; v.raddr = ra;
    v.req = e_req; v.addr = e_addr; v.valid = e_valid; v.instr = e_instr; v.npc = e_npc;
    return v;
  endfunction

  task automatic cmp(input string name, input int idx,
                     input logic a_req, input logic [15:0] a_addr, input logic a_valid,
                     input logic [15:0] a_instr, input logic [15:0] a_npc,
                     input logic e_req, input logic [15:0] e_addr, input logic e_valid,
                     input logic [15:0] e_instr, input logic [15:0] e_npc);
    checks++;
    if ({a_req, a_addr, a_valid, a_instr, a_npc} !== {e_req, e_addr, e_valid, e_instr, e_npc}) begin
      errors++;
      $display("FAIL %s[%0d] got req=%b addr=%h valid=%b instr=%h npc=%h want req=%b addr=%h valid=%b instr=%h npc=%h",
               name, idx, a_req, a_addr, a_valid, a_instr, a_npc,
               e_req, e_addr, e_valid, e_instr, e_npc);
    end
  endtask

  task automatic clear_inputs();
    stall = 1'b0; bp = 1'b0; tgt = 16'h0000; rex = 1'b0; raddr = 16'h0000;
  endtask

  // Called at a falling edge; each vector covers one clock cycle.
  task automatic run_vecs(input string name, input int first, input int n);
    for (int i = 0; i < n; i++) begin
      vec_t v;
      v = vecs[first + i];
      stall = v.stall; bp = v.bp; tgt = v.tgt; rex = v.rex; raddr = v.raddr;
      #1;
      cmp(name, i + 1, req, addr, valid, instr, npc, v.req, v.addr, v.valid, v.instr, v.npc);
      @(negedge clk);
    end
    clear_inputs();
  endtask

  task automatic do_reset(input int w);
    @(negedge clk);
    rst = 1'b1; force_ack = 1'b0; ack_wait = w;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    // Zero-wait memory: fill, stall, predicted redirect, double redirect.
    vecs[0]  = mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000, 0, 16'h0000, 16'h0000);
    vecs[1]  = mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0001, 1, 16'hA5A5, 16'h0001);
    vecs[2]  = mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0002, 1, 16'hA5A4, 16'h0002);
    vecs[3]  = mk(1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0003, 1, 16'hA5A7, 16'h0003);
    vecs[4]  = mk(1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0004, 1, 16'hA5A7, 16'h0003);
    vecs[5]  = mk(1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0004, 1, 16'hA5A7, 16'h0003);
    vecs[6]  = mk(1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0004, 1, 16'hA5A7, 16'h0003);
    vecs[7]  = mk(1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0004, 1, 16'hA5A7, 16'h0003);
    vecs[8]  = mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0004, 1, 16'hA5A7, 16'h0003);
    vecs[9]  = mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0004, 1, 16'hA5A6, 16'h0004);
    vecs[10] = mk(1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0005, 1, 16'hA5A1, 16'h0005);
    vecs[11] = mk(1, 1, 16'h0040, 0, 16'h0000, 0, 16'h0006, 1, 16'hA5A1, 16'h0005);
    vecs[12] = mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0040, 0, 16'h0000, 16'h0000);
    vecs[13] = mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0041, 1, 16'hA5E5, 16'h0041);
    vecs[14] = mk(0, 1, 16'h0300, 1, 16'h0200, 1, 16'h0042, 1, 16'hA5E4, 16'h0042);
    vecs[15] = mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0200, 0, 16'h0000, 16'h0000);
    vecs[16] = mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0201, 1, 16'hA7A5, 16'h0201);
    vecs[17] = mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0202, 1, 16'hA7A4, 16'h0202);
    // Three-cycle memory: redirects while a request is outstanding.
    vecs[18] = mk(0, 0, 16'h0000, 1, 16'h0009, 1, 16'h0000, 0, 16'h0000, 16'h0000);
    vecs[19] = mk(0, 0, 16'h0000, 1, 16'h0005, 1, 16'h0000, 0, 16'h0000, 16'h0000);
    vecs[20] = mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000, 0, 16'h0000, 16'h0000);
    vecs[21] = mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0005, 0, 16'h0000, 16'h0000);
    vecs[22] = mk(0, 0, 16'h0000, 1, 16'h0100, 1, 16'h0005, 0, 16'h0000, 16'h0000);
    vecs[23] = mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0005, 0, 16'h0000, 16'h0000);
    vecs[24] = mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0100, 0, 16'h0000, 16'h0000);
    vecs[25] = mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0100, 0, 16'h0000, 16'h0000);
    vecs[26] = mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0100, 0, 16'h0000, 16'h0000);
    vecs[27] = mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0101, 1, 16'hA4A5, 16'h0101);

    rst = 1'b1; force_ack = 1'b0; ack_wait = 0;
    clear_inputs();
    #2;
    cmp("reset", 0, req, addr, valid, instr, npc, 0, 16'h0000, 0, 16'h0000, 16'h0000);
    cmp("reset_wrap", 0, req2, addr2, valid2, instr2, npc2, 0, 16'hFFFF, 0, 16'h0000, 16'h0000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_vecs("stream", 0, 18);

    do_reset(2);
    run_vecs("drain", 18, 10);

    // PC wrap on the instance that starts at 16'hFFFF.
    do_reset(0);
    #1;
    cmp("wrap", 1, req2, addr2, valid2, instr2, npc2, 1, 16'hFFFF, 0, 16'h0000, 16'h0000);
    @(negedge clk); #1;
    cmp("wrap", 2, req2, addr2, valid2, instr2, npc2, 1, 16'h0000, 1, 16'h5A5A, 16'h0000);
    @(negedge clk); #1;
    cmp("wrap", 3, req2, addr2, valid2, instr2, npc2, 1, 16'h0001, 1, 16'hA5A5, 16'h0001);

    // Reset pulse while a request to address 4 is outstanding.
    do_reset(0);
    repeat (4) @(negedge clk);
    ack_wait = 2;
    #1;
    cmp("pre_rst", 1, req, addr, valid, instr, npc, 1, 16'h0004, 1, 16'hA5A6, 16'h0004);
    @(negedge clk); #1;
    cmp("pre_rst", 2, req, addr, valid, instr, npc, 1, 16'h0004, 0, 16'h0000, 16'h0000);
    #1 rst = 1'b1;
    #1;
    cmp("rst_pulse", 1, req, addr, valid, instr, npc, 0, 16'h0000, 0, 16'h0000, 16'h0000);
    force_ack = 1'b1;
    @(negedge clk); #1;
    cmp("stray_ack", 1, req, addr, valid, instr, npc, 0, 16'h0000, 0, 16'h0000, 16'h0000);
    @(negedge clk);
    force_ack = 1'b0;
    rst = 1'b0;
    #1;
    cmp("post_rst", 1, req, addr, valid, instr, npc, 1, 16'h0000, 0, 16'h0000, 16'h0000);
    repeat (3) @(negedge clk);
    #1;
    cmp("post_rst", 2, req, addr, valid, instr, npc, 1, 16'h0001, 1, 16'hA5A5, 16'h0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
